async_reset_seq: RTL and testbench
==================================

Name: async_reset_seq

Overview:
- Parametrised multi-source reset controller and sequencer.
- Captures one master async reset and NUM_SRC async reset requests; a request may be a level, a posedge or a sub-cycle glitch.
- Stretches the combined reset for a programmable minimum hold, then releases NUM_OUT reset domains in a staggered order.
- Keeps a sticky cause register for firmware.
- Sits at the top of the design, ahead of every synchronous block.

Parameters:
NUM_SRC, 3, number of async reset request inputs (>=1)
SYNC_STAGES, 2, synchroniser depth for each request and for master release (>=2)
HOLD_CYCLES, 4, cycles held in HOLD after all requests clear (>=1)
NUM_OUT, 3, number of sequenced reset domains (>=1)
STAGGER, 2, cycles between successive domain releases (>=1)
CNT_W, clog2(max(HOLD_CYCLES,STAGGER)+1), counter width (derived, not overridable)

Ports:
clk  input  1  single clock
async_reset_in  input  1  master reset; asynchronous, active-high
src_req_in  input  NUM_SRC  async reset requests; each bit is a level or glitch
sw_req  input  1  synchronous 1-cycle software reset request
cause_clr  input  1  synchronous clear of the cause register
reset_out  output  NUM_OUT  active-high domain resets; bit 0 releases first
busy  output  1  high in any state other than IDLE
cause  output  NUM_SRC+2  sticky cause: [0]=master, [NUM_SRC:1]=src_req_in, [NUM_SRC+1]=sw_req
cause_valid  output  1  OR-reduction of cause

Behaviour:
- Master reset: async_reset_in=1 sets everything immediately, with no clock needed:
  - reset_out = all 1s, busy = 1, state = ASSERT, counters = 0;
  - cause = 1 in bit 0 only; every synchroniser stage = 1.
- Master release: async assert, sync deassert. A SYNC_STAGES-deep chain shifts 0 in after async_reset_in falls; its output is rst_s.
- Per-source capture:
  - A capture flop is async-set while src_req_in[i]=1 and loads 0 on each clk posedge.
  - A glitch between edges is therefore seen by synchroniser stage 1 at the next edge. Its output is req_s[i], SYNC_STAGES edges later.
- req_any = rst_s | (|req_s) | sw_req.
- FSM states: IDLE, ASSERT, HOLD, RELEASE.
  - IDLE: reset_out=0, busy=0. If req_any, go to ASSERT at next edge; reset_out = all 1s.
  - ASSERT: reset_out = all 1s. If !req_any, go to HOLD with cnt=0.
  - HOLD: if req_any, go to ASSERT. Otherwise cnt++. When cnt==HOLD_CYCLES-1, go to RELEASE: clear reset_out[0], set idx=1, cnt=0.
  - RELEASE: if req_any, go to ASSERT and re-assert every reset_out bit at that edge. Otherwise, every STAGGER cycles clear reset_out[idx] and increment idx. The edge that clears reset_out[NUM_OUT-1] also enters IDLE. With NUM_OUT=1, HOLD goes straight to IDLE.
- Timing from the falling edge of async_reset_in (no other requests):
  - reset_out[0] falls at clk edge SYNC_STAGES+1+HOLD_CYCLES;
  - reset_out[k] falls STAGGER*k edges after that;
  - busy falls with the last bit.
- Latency from a src glitch in IDLE to reset_out rising: SYNC_STAGES+1 edges.
- Latency from sw_req to reset_out rising: 1 edge.
- Minimum assertion of reset_out: HOLD_CYCLES+1 cycles.
- Cause register:
  - Sets bit j at each edge where the matching req_s/sw_req is 1.
  - Cleared to 0 by cause_clr only in IDLE; cause_clr is ignored elsewhere.
  - If a set and cause_clr hit the same bit on the same edge, the set wins.
  - Survives source and software resets; only the master reset reinitialises it.
- Held request (src_req_in stuck high): stays in ASSERT indefinitely and the cause bit stays set.
- Outputs are registered and glitch-free. async_reset_in is the only async path to any output.

Decomposition:
- Shared package:
  - state enum (IDLE/ASSERT/HOLD/RELEASE);
  - cause bit index constants CAUSE_MASTER=0, CAUSE_SRC_BASE=1, and CAUSE_SW as a function of NUM_SRC;
  - clog2 helper.
- Sub-module async_req_capture:
  - one async-set capture flop plus a SYNC_STAGES chain, parameter STAGES;
  - instantiated NUM_SRC times;
  - the master release chain is an inline async-preset shift register.

Test Plan:
- Power-on: async_reset_in=1 for 3 cycles, then 0 between edges.
  - During reset: reset_out=3'b111, cause=5'b00001.
  - reset_out[0] falls at edge 7, [1] at edge 9, [2] at edge 11; busy=0 at edge 11.
- 1 ns glitch on src_req_in[1] mid-cycle in IDLE:
  - reset_out=3'b111 at edge 3, cause=5'b00101.
  - reset_out[0] falls at edge 8; minimum hold of 5 cycles met.
- sw_req pulse in IDLE: reset_out=3'b111 at the next edge, cause bit 4 set; release follows 4+2+2 cycles later.
- Re-trigger in RELEASE: src_req_in[0] glitch when reset_out=3'b110:
  - reset_out returns to 3'b111 at request edge+3;
  - HOLD restarts with the full sequence; cause shows both sources.
- Cause clear:
  - cause_clr in IDLE gives cause=0 at the next edge.
  - cause_clr during ASSERT is ignored.
  - cause_clr with a simultaneous sw_req in IDLE leaves bit 4 = 1.
- Stuck source: src_req_in[2]=1 for 50 cycles keeps the FSM in ASSERT and reset_out=3'b111. Release is 3+4 edges after deassertion.

Source files
------------

// File: rtl/async_reset_seq_pkg.sv
// Shared definitions for the reset controller: FSM states, cause-bit layout
// and a constant-evaluable log2 helper.
package async_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam int CAUSE_MASTER   = 0;
    localparam int CAUSE_SRC_BASE = 1;

    function automatic int cause_sw(input int num_src);
        return num_src + 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/async_reset_seq_req_capture.sv
// One asynchronous reset request: an async-set capture flop that turns
// sub-cycle glitches into a full-cycle pulse, followed by a synchroniser.
module async_req_capture #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic req_s_o
);

    logic              cap_q;
    logic [STAGES-1:0] sync_q;

    // Held set while the request is high; cleared on the first edge after it drops.
    always_ff @(posedge clk_i or posedge req_i) begin
        if (req_i) cap_q <= 1'b1;
        else       cap_q <= 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[STAGES-2:0], cap_q};
    end

    assign req_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_reset_seq.sv
// Multi-source reset controller: merges master, external and software resets,
// stretches the result and releases the reset domains one after another.
module async_reset_seq
    import async_reset_seq_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_OUT     = 3,
    parameter int STAGGER     = 2
) (
    input  logic                 clk,
    input  logic                 async_reset_in,
    input  logic [NUM_SRC-1:0]   src_req_in,
    input  logic                 sw_req,
    input  logic                 cause_clr,
    output logic [NUM_OUT-1:0]   reset_out,
    output logic                 busy,
    output logic [NUM_SRC+1:0]   cause,
    output logic                 cause_valid
);

    localparam int CNT_W    = clog2(((HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER) + 1);
    localparam int IDX_W    = clog2(NUM_OUT + 1);
    localparam int CW       = NUM_SRC + 2;
    localparam int CAUSE_SW = cause_sw(NUM_SRC);
    localparam logic [CW-1:0] CAUSE_RST = CW'(1) << CAUSE_MASTER;

    logic [SYNC_STAGES-1:0] mst_sync_q;
    logic                   rst_s;
    logic [NUM_SRC-1:0]     req_s;
    logic                   req_any;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rout_q, rout_d;
    logic               busy_q;
    logic [CW-1:0]      cause_q, cause_d, cause_set;
    logic               cv_q;

    // Master release: asserted asynchronously, released through the chain.
    always_ff @(posedge clk or posedge async_reset_in) begin
        if (async_reset_in) mst_sync_q <= '1;
        else                mst_sync_q <= {mst_sync_q[SYNC_STAGES-2:0], 1'b0};
    end
    assign rst_s = mst_sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        async_req_capture #(.STAGES(SYNC_STAGES)) u_cap (
            .clk_i   (clk),
            .rst_i   (async_reset_in),
            .req_i   (src_req_in[i]),
            .req_s_o (req_s[i])
        );
    end

    assign req_any = rst_s | (|req_s) | sw_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rout_d  = rout_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_ASSERT;
                    rout_d  = '1;
                end
            end
            ST_ASSERT: begin
                rout_d = '1;
                if (!req_any) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (req_any) begin
                    state_d = ST_ASSERT;
                    rout_d  = '1;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    rout_d[0] = 1'b0;
                    cnt_d     = '0;
                    idx_d     = IDX_W'(1);
                    state_d   = (NUM_OUT == 1) ? ST_IDLE : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (req_any) begin
                    state_d = ST_ASSERT;
                    rout_d  = '1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    for (int k = 1; k < NUM_OUT; k++) begin
                        if (idx_q == IDX_W'(k)) rout_d[k] = 1'b0;
                    end
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_OUT - 1)) state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ASSERT;
                rout_d  = '1;
            end
        endcase
    end

    // Request synchronisers are preset alongside the master chain, so their
    // ones during master release are not real source causes.
    always_comb begin
        cause_set                            = '0;
        cause_set[CAUSE_MASTER]              = rst_s;
        cause_set[CAUSE_SRC_BASE +: NUM_SRC] = req_s & {NUM_SRC{~rst_s}};
        cause_set[CAUSE_SW]                  = sw_req;
        cause_d = ((cause_clr && (state_q == ST_IDLE)) ? '0 : cause_q) | cause_set;
    end

    always_ff @(posedge clk or posedge async_reset_in) begin
        if (async_reset_in) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rout_q  <= '1;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_RST;
            cv_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rout_q  <= rout_d;
            busy_q  <= (state_d != ST_IDLE);
            cause_q <= cause_d;
            cv_q    <= |cause_d;
        end
    end

    assign reset_out   = rout_q;
    assign busy        = busy_q;
    assign cause       = cause_q;
    assign cause_valid = cv_q;

endmodule

// File: tb/tb_async_reset_seq.sv
// Randomised bench for async_reset_seq with a release-time reference model
// feeding a per-cycle scoreboard.
module tb_async_reset_seq;

    localparam int NUM_SRC     = 3;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 4;
    localparam int NUM_OUT     = 3;
    localparam int STAGGER     = 2;
    localparam int CW          = NUM_SRC + 2;
    localparam int D           = 16;
    localparam int REL_LAST    = 1 + HOLD_CYCLES + STAGGER * (NUM_OUT - 1);

    typedef struct packed {
        logic [NUM_OUT-1:0] rout;
        logic               busy;
        logic [CW-1:0]      cause;
        logic               cv;
    } exp_t;

    logic               clk;
    logic               async_reset_in;
    logic [NUM_SRC-1:0] src_req_in;
    logic               sw_req;
    logic               cause_clr;
    logic [NUM_OUT-1:0] reset_out;
    logic               busy;
    logic [CW-1:0]      cause;
    logic               cause_valid;

    int checks;
    int errors;
    int n;
    int gl_cnt [NUM_SRC];
    exp_t exp_q[$];

    async_reset_seq #(
        .NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES),
        .NUM_OUT(NUM_OUT), .STAGGER(STAGGER)
    ) dut (
        .clk(clk), .async_reset_in(async_reset_in), .src_req_in(src_req_in),
        .sw_req(sw_req), .cause_clr(cause_clr), .reset_out(reset_out),
        .busy(busy), .cause(cause), .cause_valid(cause_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, n);
        end
    endtask

    // Reference model: a request seen at an edge pins every domain in reset;
    // domain k is released 1+HOLD+STAGGER*k edges after the last such edge.
    logic [NUM_SRC-1:0] due [D];
    logic [NUM_SRC-1:0] src_prev, seen, reqs;
    int                 gl_last [NUM_SRC];
    int                 last_e, rst_until;
    logic [CW-1:0]      m_cause;
    logic               m_rst, was_idle;
    exp_t               m_e;

    initial begin
        n = 0; last_e = -100; rst_until = -100; m_cause = '0; src_prev = '0;
        for (int d = 0; d < D; d++) due[d] = '0;
        for (int i = 0; i < NUM_SRC; i++) gl_last[i] = 0;
        forever begin
            @(posedge clk);
            n++;
            seen = src_req_in | src_prev;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gl_cnt[i] != gl_last[i]) begin
                    seen[i] = 1'b1;
                    gl_last[i] = gl_cnt[i];
                end
            end
            src_prev = src_req_in;
            if (async_reset_in) begin
                for (int d = 0; d < D; d++) due[d] = '0;
                m_cause = CW'(1);
                last_e = n;
                rst_until = n + SYNC_STAGES;
            end else begin
                reqs = due[n % D];
                due[n % D] = '0;
                due[(n + SYNC_STAGES) % D] = due[(n + SYNC_STAGES) % D] | seen;
                m_rst = (n <= rst_until);
                was_idle = ((n - 1) >= last_e + REL_LAST);
                if (cause_clr && was_idle) m_cause = '0;
                if (m_rst) m_cause[0] = 1'b1;
                else m_cause[NUM_SRC:1] = m_cause[NUM_SRC:1] | reqs;
                if (sw_req) m_cause[NUM_SRC+1] = 1'b1;
                if (m_rst || (reqs != '0) || sw_req) last_e = n;
            end
            for (int k = 0; k < NUM_OUT; k++)
                m_e.rout[k] = (n < last_e + 1 + HOLD_CYCLES + STAGGER * k);
            m_e.busy  = (n < last_e + REL_LAST);
            m_e.cause = m_cause;
            m_e.cv    = |m_cause;
            exp_q.push_back(m_e);
        end
    end

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("reset_out",   32'(reset_out),   32'(mon_e.rout));
                chk("busy",        32'(busy),        32'(mon_e.busy));
                chk("cause",       32'(cause),       32'(mon_e.cause));
                chk("cause_valid", 32'(cause_valid), 32'(mon_e.cv));
            end
        end
    end

    task automatic glitch(input int i);
        @(negedge clk);
        #2;
        src_req_in[i] = 1'b1;
        gl_cnt[i] = gl_cnt[i] + 1;
        #1;
        src_req_in[i] = 1'b0;
    endtask

    task automatic hold_src(input int i, input int len);
        @(negedge clk); #1;
        src_req_in[i] = 1'b1;
        repeat (len) @(negedge clk);
        #1;
        src_req_in[i] = 1'b0;
    endtask

    task automatic pulse(input logic do_sw, input logic do_clr);
        @(negedge clk); #1;
        sw_req = do_sw;
        cause_clr = do_clr;
        @(negedge clk); #1;
        sw_req = 1'b0;
        cause_clr = 1'b0;
    endtask

    task automatic master_check();
        chk("async_reset_out", 32'(reset_out),   32'h7);
        chk("async_busy",      32'(busy),        32'h1);
        chk("async_cause",     32'(cause),       32'h01);
        chk("async_cv",        32'(cause_valid), 32'h1);
    endtask

    task automatic master_pulse(input int len);
        @(negedge clk); #1;
        async_reset_in = 1'b1;
        #1;
        master_check();
        repeat (len) @(negedge clk);
        #1;
        async_reset_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle", 32'(busy), 32'h0);
    endtask

    task automatic wait_rout(input logic [NUM_OUT-1:0] v, input int budget);
        int k;
        k = 0;
        while (reset_out !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_rout", 32'(reset_out), 32'(v));
    endtask

    initial begin
        async_reset_in = 1'b0; src_req_in = '0; sw_req = 1'b0; cause_clr = 1'b0;
        checks = 0; errors = 0;
        for (int i = 0; i < NUM_SRC; i++) gl_cnt[i] = 0;

        // Power-on reset, checked before any clock edge.
        #1 async_reset_in = 1'b1;
        #1 master_check();
        repeat (3) @(negedge clk);
        #1 async_reset_in = 1'b0;
        wait_idle(30);

        glitch(1);
        wait_idle(30);

        pulse(1'b1, 1'b0);
        wait_idle(30);

        // Re-trigger while domains are being released.
        glitch(1);
        wait_rout(3'b110, 30);
        glitch(0);
        wait_idle(40);

        // Cause clear: in IDLE, during ASSERT, and racing a software request.
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_idle(30);
        pulse(1'b1, 1'b1);
        wait_idle(30);

        hold_src(2, 50);
        wait_idle(40);

        master_pulse(2);
        wait_idle(40);

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1:    repeat ($urandom_range(1, 15)) @(negedge clk);
                2, 3:    glitch(int'($urandom_range(0, NUM_SRC - 1)));
                4:       pulse(1'b1, 1'b0);
                5, 6:    pulse(1'($urandom_range(0, 1)), 1'b1);
                7, 8:    hold_src(int'($urandom_range(0, NUM_SRC - 1)), int'($urandom_range(1, 8)));
                default: master_pulse(int'($urandom_range(1, 3)));
            endcase
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle(60);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
